bcd_subtractor_serial: RTL
==========================

BCD_SUBTRACTOR_SERIAL -- requirements
Module: bcd_subtractor_serial

Interface
REQ-001 SHALL have parameter: DIGITS, default 4, number of BCD digits per operand (min 1).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, the single clock.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: a  input  4*DIGITS  minuend, packed BCD, digit 0 in bits [3:0].
REQ-006 SHALL have port: b  input  4*DIGITS  subtrahend, packed BCD, same layout.
REQ-007 SHALL have port: busy  output  1  high while in SUB or FIX.
REQ-008 SHALL have port: done  output  1  one-cycle pulse when diff/sign are valid.
REQ-009 SHALL have port: diff  output  4*DIGITS  magnitude |a-b|, packed BCD.
REQ-010 SHALL have port: sign  output  1  1 = result negative (a<b).
REQ-011 SHALL have port: invalid  output  1  1 = last captured operand held a digit >9.

Function
REQ-012 SHALL use states IDLE, SUB, FIX, DONE; all outputs registered.
REQ-013 In IDLE with start=1 SHALL capture a and b into internal registers, clear the digit index and set the carry to 1, then go to SUB.
REQ-014 SUB SHALL process one digit per cycle, least significant first: a_i + (9 - b_i) + carry, with BCD correction (+6 and carry out when the raw sum is >9); the result digit is shifted into the result register.
REQ-015 After DIGITS SUB cycles, if the final carry is 1, SHALL set sign=0 and diff=result, then go to DONE.
REQ-016 After DIGITS SUB cycles, if the final carry is 0, SHALL go to FIX with the carry set to 1.
REQ-017 FIX SHALL replace each result digit with (9 - r_i) + carry, with BCD correction, one digit per cycle, LSD first, for DIGITS cycles; it then sets sign=1 and loads diff, and goes to DONE.
REQ-018 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-019 Latency from the start sample edge to done high SHALL be DIGITS+1 cycles when a>=b and 2*DIGITS+1 cycles when a<b.
REQ-020 A zero result (a==b) SHALL yield sign=0 and diff=0; negative zero never occurs.
REQ-021 start SHALL be ignored in SUB, FIX and DONE; no queuing.
REQ-022 diff, sign and invalid SHALL hold their values until the next done pulse.
REQ-023 Operands SHALL be captured at the start edge; changes on a and b after that edge have no effect.

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, busy=0, done=0, diff=0, sign=0, invalid=0, and clear all internal registers, regardless of the clock.
REQ-025 Reset asserted during SUB or FIX SHALL abort the operation; no done pulse is produced for the aborted request.
REQ-026 After rst deasserts, the first rising edge with start=1 SHALL begin a new operation.

Configuration
REQ-027 Macro BCD_SUB_INPUT_CHECK_EN SHALL control input checking.
REQ-028 With BCD_SUB_INPUT_CHECK_EN defined, at capture SHALL test every digit of a and b; if any digit is >9, the block goes directly to DONE (done pulses 1 cycle after start) with invalid=1, diff=0 and sign=0.
REQ-029 With BCD_SUB_INPUT_CHECK_EN defined, a valid capture SHALL set invalid=0.
REQ-030 Without BCD_SUB_INPUT_CHECK_EN, invalid SHALL be constant 0 and digits >9 SHALL be processed by the normal datapath; the result is deterministic but not specified.

Verification (DIGITS=4)
REQ-031 SHALL cover: a=5432, b=1234, start at edge 0 -> done high in cycle 5, diff=4198, sign=0.
REQ-032 SHALL cover: a=1234, b=5432 -> done high in cycle 9, diff=4198, sign=1, busy high in cycles 1-8.
REQ-033 SHALL cover: a=0000, b=0001 -> diff=0001, sign=1; a=7777, b=7777 -> diff=0000, sign=0, done in cycle 5.
REQ-034 SHALL cover: start pulsed again in cycle 3 of a 5432-1234 operation -> ignored; a single done pulse; result 4198.
REQ-035 SHALL cover: rst asserted mid-FIX of 1234-5432 -> all outputs 0 asynchronously; no done; a subsequent 0009-0003 request gives diff=0006, sign=0.
REQ-036 SHALL cover: with BCD_SUB_INPUT_CHECK_EN defined, a=12A4 -> done in cycle 1, invalid=1, diff=0; without the macro -> invalid stays 0.

Source files
------------

// File: rtl/bcd_subtractor_serial.sv
// Serial packed-BCD subtractor: one digit per cycle, ten's-complement fix-up for negative results.
// Optional input digit checking is enabled by defining BCD_SUB_INPUT_CHECK_EN.
module bcd_subtractor_serial #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   diff,
    output logic                  sign,
    output logic                  invalid
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        FIX,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    opA_q, opA_d;
    logic [W-1:0]    opB_q, opB_d;
    logic [W-1:0]    res_q, res_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    diff_q, diff_d;
    logic            sign_q, sign_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [4:0]      step;
`ifdef BCD_SUB_INPUT_CHECK_EN
    logic            invalid_q, invalid_d;
`endif

    // One BCD digit add with decimal correction; returns {carryOut, digit}.
    function automatic logic [4:0] bcdDigitAdd(input logic [3:0] x, input logic [3:0] y,
                                               input logic cin);
        logic [4:0] raw;
        logic [4:0] adj;
        raw = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
        adj = raw + 5'd6;
        if (raw > 5'd9) begin
            return {1'b1, adj[3:0]};
        end
        return {1'b0, raw[3:0]};
    endfunction

`ifdef BCD_SUB_INPUT_CHECK_EN
    function automatic logic hasBadDigit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        res_d   = res_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        diff_d  = diff_q;
        sign_d  = sign_q;
        step    = 5'd0;
`ifdef BCD_SUB_INPUT_CHECK_EN
        invalid_d = invalid_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    opA_d   = a;
                    opB_d   = b;
                    res_d   = '0;
                    idx_d   = '0;
                    carry_d = 1'b1;
                    state_d = SUB;
`ifdef BCD_SUB_INPUT_CHECK_EN
                    invalid_d = 1'b0;
                    if (hasBadDigit(a) || hasBadDigit(b)) begin
                        invalid_d = 1'b1;
                        diff_d    = '0;
                        sign_d    = 1'b0;
                        state_d   = DONE;
                    end
`endif
                end
            end

            // Digit result enters at the top so digit 0 ends up in bits [3:0] after DIGITS shifts.
            SUB: begin
                step    = bcdDigitAdd(opA_q[3:0], 4'd9 - opB_q[3:0], carry_q);
                res_d   = (res_q >> 4) | (W'(step[3:0]) << (W - 4));
                opA_d   = opA_q >> 4;
                opB_d   = opB_q >> 4;
                carry_d = step[4];
                idx_d   = idx_q + IW'(1);
                if (idx_q == LAST) begin
                    idx_d = '0;
                    if (step[4]) begin
                        diff_d  = res_d;
                        sign_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        carry_d = 1'b1;
                        state_d = FIX;
                    end
                end
            end

            // No final carry means the result is a ten's complement; re-complement it here.
            FIX: begin
                step    = bcdDigitAdd(4'd9 - res_q[3:0], 4'd0, carry_q);
                res_d   = (res_q >> 4) | (W'(step[3:0]) << (W - 4));
                carry_d = step[4];
                idx_d   = idx_q + IW'(1);
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    diff_d  = res_d;
                    sign_d  = 1'b1;
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SUB) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            opA_q     <= '0;
            opB_q     <= '0;
            res_q     <= '0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            diff_q    <= '0;
            sign_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef BCD_SUB_INPUT_CHECK_EN
            invalid_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            res_q     <= res_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            diff_q    <= diff_d;
            sign_q    <= sign_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef BCD_SUB_INPUT_CHECK_EN
            invalid_q <= invalid_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign sign = sign_q;
`ifdef BCD_SUB_INPUT_CHECK_EN
    assign invalid = invalid_q;
`else
    assign invalid = 1'b0;
`endif

endmodule
